// File: rtl/spirose_fb_pkg.sv
// Shared constants, state encoding and address helpers for the framebuffer
// reader. The framebuffer is laid out column-major: column, then row, then word.
package spirose_fb_pkg;

  localparam int COLUMN_COUNT  = 128;
  localparam int MUX_COUNT     = 8;
  localparam int WORDS_PER_MUX = 768;
  localparam int DATA_W        = 30;
  localparam int FIFO_DEPTH    = 4;
  localparam int ADDR_W        = $clog2(COLUMN_COUNT * MUX_COUNT * WORDS_PER_MUX);

  localparam int COL_W  = $clog2(COLUMN_COUNT);
  localparam int ROW_W  = $clog2(MUX_COUNT);
  localparam int WORD_W = $clog2(WORDS_PER_MUX);

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLUMN_COUNT - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(MUX_COUNT - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS_PER_MUX - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } fb_state_t;

  // Linear RAM address of (col, row, word); all arithmetic stays at ADDR_W.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [COL_W-1:0]  col,
                                                input logic [ROW_W-1:0]  row,
                                                input logic [WORD_W-1:0] word);
    logic [ADDR_W-1:0] line;
    line = ADDR_W'(col) * ADDR_W'(MUX_COUNT) + ADDR_W'(row);
    return line * ADDR_W'(WORDS_PER_MUX) + ADDR_W'(word);
  endfunction

  // One-hot row select for the driver multiplexer.
  function automatic logic [MUX_COUNT-1:0] row_onehot(input logic [ROW_W-1:0] row);
    return MUX_COUNT'(1) << row;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO. The head word is held in its own
// register so the consumer sees a registered output that reads zero when empty.
module sync_fifo #(
  parameter  int DATA_W = 30,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] head;
  logic              do_push;
  logic              do_pop;
  logic [CNT_W-1:0]  remain;
  logic [PTR_W-1:0]  rd_next;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Entries that survive this cycle's pop, and where the next head lives.
  assign remain  = count - CNT_W'(do_pop);
  assign rd_next = rd_ptr + PTR_W'(do_pop);
  assign rdata   = head;

  // Storage array: data only, never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Head register: next stored word, else the word arriving into an empty FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
    end else if (remain != '0) begin
      head <= mem[rd_next];
    end else if (do_push) begin
      head <= wdata;
    end else begin
      head <= '0;
    end
  end

endmodule

// File: rtl/framebuffer_reader.sv
// Streams one rotation slice of LED data from the framebuffer RAM to the
// driver controller, one 30-bit word per cycle under valid/ready, and steps
// the one-hot row multiplexer each time the driver latches a row.
module framebuffer_reader
  import spirose_fb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 position_sync,
  input  logic                 column_ready,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic                 ram_rd,
  input  logic [DATA_W-1:0]    ram_q,
  output logic [DATA_W-1:0]    framebuffer_dat,
  output logic                 fb_valid,
  input  logic                 fb_ready,
  input  logic                 row_latched,
  output logic [MUX_COUNT-1:0] mux_onehot,
  output logic                 column_done,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int LVL_W = CNT_W + 1;
  localparam logic [LVL_W-1:0] LVL_LIMIT = LVL_W'(FIFO_DEPTH);

  fb_state_t         state_q;
  fb_state_t         state_d;
  logic [COL_W-1:0]  column;
  logic [COL_W-1:0]  cur_col;
  logic              pending;
  logic [ROW_W-1:0]  row;
  logic [WORD_W-1:0] word;
  logic              in_flight;
  logic              start;
  logic              issue;
  logic              finish;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  logic [LVL_W-1:0]  level;
  logic              mux_started;
  logic [ROW_W-1:0]  display_row;
  logic [ROW_W-1:0]  display_next;

  assign fb_valid = !fifo_empty;
  assign pop      = fb_valid && fb_ready;
  // Words already buffered plus the one read still coming back from RAM.
  assign level    = LVL_W'(fifo_count) + LVL_W'(in_flight);
  assign ram_rd   = issue;
  assign ram_addr = fb_addr(cur_col, row, word);

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_flight),
    .wdata (ram_q),
    .pop   (pop),
    .rdata (framebuffer_dat),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Next-state and per-cycle strobes for the column streaming FSM.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    issue   = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pending && column_ready) begin
          start   = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (level < LVL_LIMIT && !fifo_full) begin
          issue = 1'b1;
          if (row == ROW_LAST && word == WORD_LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && fifo_count == CNT_W'(1) && !in_flight) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Slice index tracking; a second sync before the first is consumed is an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      column  <= COL_LAST;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else if (position_sync) begin
      column  <= (column == COL_LAST) ? '0 : column + COL_W'(1);
      pending <= 1'b1;
      if (pending && !start) overrun <= 1'b1;
    end else if (start) begin
      pending <= 1'b0;
    end
  end

  // Read address walk: word fastest, then row, within the latched column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_col <= '0;
      row     <= '0;
      word    <= '0;
    end else if (start) begin
      cur_col <= column;
      row     <= '0;
      word    <= '0;
    end else if (issue) begin
      if (word == WORD_LAST) begin
        word <= '0;
        if (row != ROW_LAST) row <= row + ROW_W'(1);
      end else begin
        word <= word + WORD_W'(1);
      end
    end
  end

  // RAM returns data one cycle after the strobe; mark that cycle for the FIFO push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_flight <= 1'b0;
    else     in_flight <= issue;
  end

  // Registered end-of-column pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) column_done <= 1'b0;
    else     column_done <= finish;
  end

  assign display_next = (display_row == ROW_LAST) ? '0 : display_row + ROW_W'(1);

  // Row multiplexer: blank until the first latch, then cycle through the rows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mux_started <= 1'b0;
      display_row <= '0;
      mux_onehot  <= '0;
    end else if (row_latched) begin
      if (!mux_started) begin
        mux_started <= 1'b1;
        display_row <= '0;
        mux_onehot  <= row_onehot('0);
      end else begin
        display_row <= display_next;
        mux_onehot  <= row_onehot(display_next);
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_reader.sv
// Directed/randomized bench for framebuffer_reader. The RAM model returns its
// own address as data, so every popped word must equal col*6144 + index.
module tb_framebuffer_reader;
  import spirose_fb_pkg::*;

  localparam int WPC = MUX_COUNT * WORDS_PER_MUX;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 position_sync;
  logic                 column_ready;
  logic [ADDR_W-1:0]    ram_addr;
  logic                 ram_rd;
  logic [DATA_W-1:0]    ram_q = '0;
  logic [DATA_W-1:0]    framebuffer_dat;
  logic                 fb_valid;
  logic                 fb_ready;
  logic                 row_latched;
  logic [MUX_COUNT-1:0] mux_onehot;
  logic                 column_done;
  logic                 overrun;

  int n_cmp = 0;
  int n_mis = 0;

  framebuffer_reader dut (
    .clk             (clk),
    .rst             (rst),
    .position_sync   (position_sync),
    .column_ready    (column_ready),
    .ram_addr        (ram_addr),
    .ram_rd          (ram_rd),
    .ram_q           (ram_q),
    .framebuffer_dat (framebuffer_dat),
    .fb_valid        (fb_valid),
    .fb_ready        (fb_ready),
    .row_latched     (row_latched),
    .mux_onehot      (mux_onehot),
    .column_done     (column_done),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data is the address, one cycle after the strobe.
  always @(posedge clk) begin
    if (ram_rd) ram_q <= DATA_W'(ram_addr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check(tag, 64'({ram_addr, ram_rd, fb_valid, framebuffer_dat, mux_onehot, column_done, overrun}), 64'd0);
  endtask

  task automatic pulse_sync();
    @(negedge clk);
    position_sync = 1'b1;
    @(negedge clk);
    position_sync = 1'b0;
  endtask

  // Consume one column (or its first 'limit' words) and score it against the
  // address-order model: reads and pops must both walk col*WPC + 0,1,2,...
  task automatic run_column(input int col, input int pct, input int limit, output logic stall);
    int issued   = 0;
    int popped   = 0;
    int addr_bad = 0;
    int data_bad = 0;
    int dones    = 0;
    int max_lvl  = 0;
    int cycles   = 0;
    int tail     = 0;
    stall = 1'b0;
    while (cycles < 40000) begin
      @(negedge clk);
      cycles++;
      fb_ready = ($urandom_range(99) < pct);
      if (ram_rd) begin
        if (64'(ram_addr) !== 64'(col * WPC + issued)) addr_bad++;
        issued++;
      end else if (issued > 0 && issued < WPC) begin
        stall = 1'b1;
      end
      if (fb_valid && fb_ready) begin
        if (64'(framebuffer_dat) !== 64'(col * WPC + popped)) data_bad++;
        popped++;
      end
      if (column_done) dones++;
      if (issued - popped > max_lvl) max_lvl = issued - popped;
      if (popped >= limit) begin
        if (limit < WPC) break;
        tail++;
        if (tail > 4) break;
      end
    end
    fb_ready = 1'b1;
    check($sformatf("col%0d_pops", col), 64'(popped), 64'(limit));
    check($sformatf("col%0d_bad_addrs", col), 64'(addr_bad), 64'd0);
    check($sformatf("col%0d_bad_words", col), 64'(data_bad), 64'd0);
    check($sformatf("col%0d_level_le_depth", col), 64'(max_lvl <= FIFO_DEPTH), 64'd1);
    if (limit == WPC) begin
      check($sformatf("col%0d_reads", col), 64'(issued), 64'(WPC));
      check($sformatf("col%0d_done_pulses", col), 64'(dones), 64'd1);
      check($sformatf("col%0d_empty_after", col), 64'(fb_valid), 64'd0);
    end else begin
      check($sformatf("col%0d_no_early_done", col), 64'(dones), 64'd0);
    end
  endtask

  initial begin
    logic [MUX_COUNT-1:0] mux_exp;
    logic                 stall;
    int                   rd_seen;

    rst           = 1'b1;
    position_sync = 1'b0;
    column_ready  = 1'b0;
    fb_ready      = 1'b0;
    row_latched   = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check_quiet("after_release");

    // Row mux: blank until first latch, then 0x01..0x80 and wrap to 0x01.
    mux_exp = '0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check($sformatf("mux_hold%0d", i), 64'(mux_onehot), 64'(mux_exp));
      row_latched = 1'b1;
      @(negedge clk);
      row_latched = 1'b0;
      mux_exp = MUX_COUNT'(1) << (i % MUX_COUNT);
      check($sformatf("mux_step%0d", i), 64'(mux_onehot), 64'(mux_exp));
    end

    // Back-to-back columns with a consumer that is always ready.
    column_ready = 1'b1;
    fb_ready     = 1'b1;
    pulse_sync();
    run_column(0, 100, WPC, stall);
    check("overrun_clean", 64'(overrun), 64'd0);
    pulse_sync();
    run_column(1, 100, WPC, stall);

    // Consumer stalls ~30% of cycles: reads must throttle, nothing lost.
    pulse_sync();
    run_column(2, 70, WPC, stall);
    check("read_stall_seen", 64'(stall), 64'd1);

    // Two syncs before the driver is ready: only the later slice is streamed.
    column_ready = 1'b0;
    pulse_sync();
    check("no_overrun_single", 64'(overrun), 64'd0);
    pulse_sync();
    check("overrun_set", 64'(overrun), 64'd1);
    @(negedge clk);
    column_ready = 1'b1;
    run_column(4, 100, WPC, stall);
    check("overrun_sticky", 64'(overrun), 64'd1);
    rd_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ram_rd || fb_valid) rd_seen++;
    end
    check("no_extra_column", 64'(rd_seen), 64'd0);

    // Reset in the middle of a column, then a clean restart at column 0.
    pulse_sync();
    run_column(5, 100, 300, stall);
    #2 rst = 1'b1;
    #1 check_quiet("async_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_quiet("post_reset");
    pulse_sync();
    run_column(0, 100, WPC, stall);
    check("overrun_cleared", 64'(overrun), 64'd0);

    // Walk the index to the last slice, stream it, then wrap back to 0.
    column_ready = 1'b0;
    repeat (127) pulse_sync();
    @(negedge clk);
    column_ready = 1'b1;
    run_column(127, 100, WPC, stall);
    pulse_sync();
    run_column(0, 100, WPC, stall);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/framebuffer_reader.md
Name: framebuffer_reader

Overview:
- Upstream feeder of driver_controller.
- Reads one column (one rotation slice) of LED data from the framebuffer RAM read port. Streams it as 30-bit words, one bit per driver chain, via a valid/ready handshake.
- Drives the 8-bit one-hot row multiplex (fpga_mul) in step with driver latches.
- Replaces the constant framebuffer_dat/fpga_mul tie-offs used in bring-up.

Parameters:
- COLUMN_COUNT, 128, slices per rotation; column index wraps at this value.
- MUX_COUNT, 8, multiplexed rows per column; width of mux_onehot.
- WORDS_PER_MUX, 768, words per row (16 channels x 48 bits).
- DATA_W, 30, driver chains; width of RAM data and framebuffer_dat.
- FIFO_DEPTH, 4, output prefetch FIFO entries (power of 2, >= 2).
- ADDR_W, $clog2(COLUMN_COUNT*MUX_COUNT*WORDS_PER_MUX), RAM address width (20 at defaults).

Ports:
- clk  in  1  system clock (66 MHz PLL output).
- rst  in  1  asynchronous, active-high reset.
- position_sync  in  1  one-cycle pulse: rotor reached next slice.
- column_ready  in  1  driver_controller can accept a new column.
- ram_addr  out  ADDR_W  framebuffer read address.
- ram_rd  out  1  read strobe; data returns exactly 1 cycle later.
- ram_q  in  DATA_W  read data.
- framebuffer_dat  out  DATA_W  head-of-FIFO word.
- fb_valid  out  1  framebuffer_dat is valid.
- fb_ready  in  1  consumer pops the word this cycle when fb_valid=1.
- row_latched  in  1  one-cycle pulse: driver_controller latched a full row.
- mux_onehot  out  MUX_COUNT  row select to fpga_mul_a/b.
- column_done  out  1  one-cycle pulse: last word of the column popped.
- overrun  out  1  sticky: a position_sync was lost.

Behaviour:
- Reset (async, rst=1) clears everything:
  - Outputs: ram_addr=0, ram_rd=0, fb_valid=0, framebuffer_dat=0, mux_onehot=0, column_done=0, overrun=0.
  - Internal: column=COLUMN_COUNT-1, pending=0, FIFO empty, display_row=0, mux_started=0, state=IDLE.
  - Reset mid-stream discards in-flight reads; a RAM return in the cycle after reset release is ignored.
- position_sync:
  - column <= (column==COLUMN_COUNT-1) ? 0 : column+1.
  - pending <= 1.
  - If pending was already 1, set overrun (sticky until rst). The column index still advances, so the latest slice wins.
- FSM states: IDLE, STREAM, DRAIN.
  - IDLE: when pending && column_ready, latch cur_col=column, clear pending, reset row=0 and word=0, go to STREAM. A same-cycle position_sync sets pending again and is not an overrun.
  - STREAM: issue a read when occupancy+in_flight < FIFO_DEPTH. Occupancy is FIFO entries; in_flight is 0 or 1.
    - ram_addr = (cur_col*MUX_COUNT + row)*WORDS_PER_MUX + word, using constant-multiply arithmetic at ADDR_W.
    - word wraps at WORDS_PER_MUX-1 and then increments row.
    - After issuing row=MUX_COUNT-1, word=WORDS_PER_MUX-1, go to DRAIN.
  - DRAIN: no reads. When the last word is popped (FIFO empty after the pop, in_flight=0), pulse column_done for 1 cycle and return to IDLE.
- RAM return: ram_q is written into the FIFO in the cycle after ram_rd=1. Space is guaranteed by the issue rule, so the FIFO never overflows.
- Output FIFO:
  - fb_valid = !empty. framebuffer_dat is the head word, driven from a register.
  - A pop happens when fb_valid && fb_ready.
  - A push and a pop in the same cycle keep occupancy unchanged.
  - Minimum latency: ram_rd to fb_valid is 2 cycles (RAM 1 + FIFO write 1).
  - fb_ready while empty is ignored.
- Words per column = MUX_COUNT*WORDS_PER_MUX (6144 at defaults). Exactly that many pops occur per column, in address order.
- Row mux:
  - On row_latched: if mux_started=0, set mux_started=1 and display_row=0. Otherwise display_row <= (display_row==MUX_COUNT-1) ? 0 : display_row+1.
  - mux_onehot = mux_started ? (1<<display_row) : 0, registered, so it updates 1 cycle after row_latched.
  - rst is the only way to blank the mux.
- position_sync during STREAM/DRAIN never aborts the current column.

Decomposition:
- Package spirose_fb_pkg:
  - constants COLUMN_COUNT, MUX_COUNT, WORDS_PER_MUX, DATA_W.
  - typedef fb_state_t {IDLE, STREAM, DRAIN}.
  - function fb_addr(col,row,word).
- Sub-module sync_fifo (DATA_W wide, FIFO_DEPTH deep; push/pop/empty/full/count; async active-high reset). All other logic lives in framebuffer_reader.

Test Plan:
- Reset then a single position_sync with column_ready=1 and fb_ready=1; RAM model returns its address -> 6144 words in order, addresses 0..6143 (column 0), then one column_done pulse; overrun=0.
- Second position_sync -> addresses 6144..12287. Force the index to 127 and sync -> index wraps to 0, addresses 0..6143.
- fb_ready toggled randomly 30% -> no word lost or duplicated, ram_rd stalls, and occupancy+in_flight never exceeds 4.
- Two position_sync pulses before column_ready rises -> overrun=1 and stays 1; only the later column is streamed.
- row_latched pulses x9 -> mux_onehot sequence 0x01,0x02,...,0x80,0x01, each 1 cycle after its pulse; 0x00 before the first pulse.
- rst asserted mid-STREAM (word 300) -> all outputs 0 asynchronously. After release plus a new sync, streaming restarts cleanly from word 0 with no stale FIFO data.
